// File: rtl/gpr_write_arbiter_pkg.sv
// Shared widths, starvation limit and arbiter state encoding for the GPR
// write arbiter and its busy-register scoreboard.
package gpr_write_arbiter_pkg;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned REG_DW       = 32;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned STARVE_LIMIT = 3;
  localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-register scoreboard: set on long-op issue, cleared on long-unit
// writeback; register 0 is never busy.
module gpr_scoreboard
  import gpr_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic [REG_AW-1:0] q1_addr_i,
  input  logic [REG_AW-1:0] q2_addr_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy1_o = busy_q[q1_addr_i];
  assign busy2_o = busy_q[q2_addr_i];

endmodule

// File: rtl/gpr_write_arbiter.sv
// Arbitrates the single GPR write port between pipeline writeback and a
// long-latency unit, with starvation escape and a busy-register scoreboard.
module gpr_write_arbiter
  import gpr_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [REG_DW-1:0] wb_data_i,
  input  logic              lu_valid_i,
  input  logic [REG_AW-1:0] lu_addr_i,
  input  logic [REG_DW-1:0] lu_data_i,
  output logic              lu_ready_o,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] issue_addr_i,
  input  logic [REG_AW-1:0] rd1_addr_i,
  input  logic [REG_AW-1:0] rd2_addr_i,
  output logic              hazard_o,
  output logic              stall_req_o,
  output logic              rd_write_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [REG_DW-1:0] write_data_o
);

  arb_state_e          state_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic                stall_req_q;
  logic                grant_lu;
  logic                grant_wb;
  logic                busy1;
  logic                busy2;

  // In FORCE the WB write is dropped; the frozen pipeline re-presents it.
  assign grant_lu = !rst && lu_valid_i && ((state_q == FORCE) || !wb_we_i);
  assign grant_wb = !rst && wb_we_i && (state_q != FORCE);

  always_comb begin
    rd_write_o   = 1'b0;
    rd_addr_o    = '0;
    write_data_o = '0;
    if (grant_lu) begin
      rd_write_o   = 1'b1;
      rd_addr_o    = lu_addr_i;
      write_data_o = lu_data_i;
    end else if (grant_wb) begin
      rd_write_o   = 1'b1;
      rd_addr_o    = wb_addr_i;
      write_data_o = wb_data_i;
    end
  end

  assign lu_ready_o  = grant_lu;
  assign stall_req_o = stall_req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      stall_req_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_we_i && lu_valid_i) begin
            state_q      <= WAIT;
            starve_cnt_q <= STARVE_W'(1);
          end
        end
        WAIT: begin
          if (!lu_valid_i || !wb_we_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            stall_req_q  <= 1'b0;
          end else begin
            starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
            if (starve_cnt_q == STARVE_W'(STARVE_LIMIT - 1)) begin
              state_q     <= FORCE;
              stall_req_q <= 1'b1;
            end
          end
        end
        FORCE: begin
          state_q      <= IDLE;
          starve_cnt_q <= '0;
          stall_req_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          starve_cnt_q <= '0;
          stall_req_q  <= 1'b0;
        end
      endcase
    end
  end

  gpr_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (issue_i),
    .set_addr_i (issue_addr_i),
    .clr_i      (grant_lu),
    .clr_addr_i (lu_addr_i),
    .q1_addr_i  (rd1_addr_i),
    .q2_addr_i  (rd2_addr_i),
    .busy1_o    (busy1),
    .busy2_o    (busy2)
  );

  assign hazard_o = !rst && (((rd1_addr_i != '0) && busy1) || ((rd2_addr_i != '0) && busy2));

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed self-checking bench for gpr_write_arbiter.
module tb_gpr_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic [4:0]  rd1_addr_i;
  logic [4:0]  rd2_addr_i;
  logic        hazard_o;
  logic        stall_req_o;
  logic        rd_write_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] write_data_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  gpr_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .lu_valid_i   (lu_valid_i),
    .lu_addr_i    (lu_addr_i),
    .lu_data_i    (lu_data_i),
    .lu_ready_o   (lu_ready_o),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .rd1_addr_i   (rd1_addr_i),
    .rd2_addr_i   (rd2_addr_i),
    .hazard_o     (hazard_o),
    .stall_req_o  (stall_req_o),
    .rd_write_o   (rd_write_o),
    .rd_addr_o    (rd_addr_o),
    .write_data_o (write_data_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid_i = v;
    lu_addr_i  = a;
    lu_data_i  = d;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_we_i   = v;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  initial begin
    rst = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    set_lu(1'b1, 5'd3, 32'h3333_3333);
    issue_i = 1'b1; issue_addr_i = 5'd3;
    rd1_addr_i = 5'd3; rd2_addr_i = 5'd0;
    tick(); tick();
    check("rst_lu_ready", {31'd0, lu_ready_o}, 32'd0);
    check("rst_rd_write", {31'd0, rd_write_o}, 32'd0);
    check("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    check("rst_wdata", write_data_o, 32'd0);
    check("rst_hazard", {31'd0, hazard_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    issue_i = 1'b0;
    set_lu(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_busy3", {31'd0, hazard_o}, 32'd0);

    // Single LU grant, scoreboard clear
    issue_i = 1'b1; issue_addr_i = 5'd5;
    tick();
    issue_i = 1'b0; rd1_addr_i = 5'd5;
    #1 check("busy5_hazard", {31'd0, hazard_o}, 32'd1);
    set_lu(1'b1, 5'd5, 32'hA5A5_A5A5);
    #1;
    check("lu_ready", {31'd0, lu_ready_o}, 32'd1);
    check("lu_rd_write", {31'd0, rd_write_o}, 32'd1);
    check("lu_rd_addr", {27'd0, rd_addr_o}, 32'd5);
    check("lu_wdata", write_data_o, 32'hA5A5_A5A5);
    check("hazard_no_bypass", {31'd0, hazard_o}, 32'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    #1;
    check("busy5_cleared", {31'd0, hazard_o}, 32'd0);
    check("idle_rd_write", {31'd0, rd_write_o}, 32'd0);
    check("idle_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    check("idle_wdata", write_data_o, 32'd0);
    check("idle_lu_ready", {31'd0, lu_ready_o}, 32'd0);

    // Hazard lifetime for addr 7
    issue_i = 1'b1; issue_addr_i = 5'd7; rd1_addr_i = 5'd7; rd2_addr_i = 5'd0;
    #1 check("hz7_before_edge", {31'd0, hazard_o}, 32'd0);
    tick();
    issue_i = 1'b0;
    #1 check("hz7_set", {31'd0, hazard_o}, 32'd1);
    tick();
    check("hz7_hold", {31'd0, hazard_o}, 32'd1);
    rd1_addr_i = 5'd0; rd2_addr_i = 5'd7;
    #1 check("hz7_rd2", {31'd0, hazard_o}, 32'd1);
    rd2_addr_i = 5'd0;
    #1 check("hz_rd0", {31'd0, hazard_o}, 32'd0);
    rd1_addr_i = 5'd7;
    set_lu(1'b1, 5'd7, 32'h0000_0077);
    #1;
    check("hz7_at_handshake", {31'd0, hazard_o}, 32'd1);
    check("lu7_ready", {31'd0, lu_ready_o}, 32'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    #1 check("hz7_cleared", {31'd0, hazard_o}, 32'd0);

    // WB grant leaves scoreboard alone; LU to r0 passes through
    issue_i = 1'b1; issue_addr_i = 5'd6;
    tick();
    issue_i = 1'b0;
    set_wb(1'b1, 5'd6, 32'h0000_0066);
    #1;
    check("wb_rd_write", {31'd0, rd_write_o}, 32'd1);
    check("wb_rd_addr", {27'd0, rd_addr_o}, 32'd6);
    check("wb_wdata", write_data_o, 32'h66);
    check("wb_lu_ready", {31'd0, lu_ready_o}, 32'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    rd1_addr_i = 5'd6;
    #1 check("wb_keeps_busy6", {31'd0, hazard_o}, 32'd1);
    set_lu(1'b1, 5'd0, 32'h0000_DEAD);
    #1;
    check("lu0_ready", {31'd0, lu_ready_o}, 32'd1);
    check("lu0_rd_write", {31'd0, rd_write_o}, 32'd1);
    check("lu0_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    check("lu0_wdata", write_data_o, 32'hDEAD);
    tick();
    set_lu(1'b1, 5'd6, 32'h0);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    #1 check("busy6_cleared", {31'd0, hazard_o}, 32'd0);

    // Same-cycle set and clear of addr 9
    issue_i = 1'b1; issue_addr_i = 5'd9;
    tick();
    set_lu(1'b1, 5'd9, 32'h9);
    rd1_addr_i = 5'd9;
    tick();
    issue_i = 1'b0;
    set_lu(1'b0, 5'd0, 32'h0);
    #1 check("busy9_set_wins", {31'd0, hazard_o}, 32'd1);
    set_lu(1'b1, 5'd9, 32'h9);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    #1 check("busy9_cleared", {31'd0, hazard_o}, 32'd0);
    rd1_addr_i = 5'd0;

    // Starvation escape
    set_wb(1'b1, 5'd2, 32'h0000_1111);
    set_lu(1'b1, 5'd4, 32'h0000_4444);
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("starve%0d_lu_ready", i), {31'd0, lu_ready_o}, 32'd0);
      check($sformatf("starve%0d_rd_addr", i), {27'd0, rd_addr_o}, 32'd2);
      check($sformatf("starve%0d_wdata", i), write_data_o, 32'h1111);
      check($sformatf("starve%0d_stall", i), {31'd0, stall_req_o}, 32'd0);
      tick();
    end
    check("force_stall", {31'd0, stall_req_o}, 32'd1);
    check("force_lu_ready", {31'd0, lu_ready_o}, 32'd1);
    check("force_rd_write", {31'd0, rd_write_o}, 32'd1);
    check("force_rd_addr", {27'd0, rd_addr_o}, 32'd4);
    check("force_wdata", write_data_o, 32'h4444);
    tick();
    check("after_force_stall", {31'd0, stall_req_o}, 32'd0);
    check("after_force_lu_ready", {31'd0, lu_ready_o}, 32'd0);
    check("after_force_rd_addr", {27'd0, rd_addr_o}, 32'd2);
    set_wb(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick();

    // Dropping lu_valid in WAIT clears the starvation count
    set_wb(1'b1, 5'd2, 32'h0000_1111);
    set_lu(1'b1, 5'd4, 32'h0000_4444);
    tick(); tick();
    lu_valid_i = 1'b0;
    #1 check("wait_drop_wb", {27'd0, rd_addr_o}, 32'd2);
    tick();
    lu_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 check($sformatf("restart%0d_stall", i), {31'd0, stall_req_o}, 32'd0);
      tick();
    end
    check("restart_force_stall", {31'd0, stall_req_o}, 32'd1);

    // Reset while in FORCE
    rst = 1'b1;
    #1;
    check("rst_force_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_force_lu_ready", {31'd0, lu_ready_o}, 32'd0);
    check("rst_force_rd_write", {31'd0, rd_write_o}, 32'd0);
    tick();
    wb_we_i = 1'b0;
    #1 check("rst_hold_lu_ready", {31'd0, lu_ready_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_lu_ready", {31'd0, lu_ready_o}, 32'd1);
    check("post_rst_rd_addr", {27'd0, rd_addr_o}, 32'd4);
    check("post_rst_wdata", write_data_o, 32'h4444);
    check("post_rst_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    #1 check("final_idle", {31'd0, rd_write_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpr_write_arbiter.md
GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 SHALL have exactly one clock and one reset; the reset is asynchronous and active-high; the ports are named clk and rst, as in the rest of the codebase.
REQ-002 clk  in  1  rising-edge clock shared with the GPR.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 wb_we_i / wb_addr_i / wb_data_i  in  1/5/32  pipeline writeback request; this requester has no backpressure.
REQ-005 lu_valid_i / lu_addr_i / lu_data_i  in  1/5/32  long-latency unit (mult/div/load) result request.
REQ-006 lu_ready_o  out  1  long-unit grant; the transfer occurs on the cycle where lu_valid_i and lu_ready_o are both high.
REQ-007 issue_i / issue_addr_i  in  1/5  a long op is issued and its destination register is marked busy.
REQ-008 rd1_addr_i / rd2_addr_i  in  5/5  decode-stage read addresses checked for hazards.
REQ-009 hazard_o  out  1  a nonzero read address targets a busy register.
REQ-010 stall_req_o  out  1  registered request to freeze the pipeline.
REQ-011 rd_write_o / rd_addr_o / write_data_o  out  1/5/32  the single GPR write port.

Function
REQ-012 SHALL use the FSM states IDLE, WAIT and FORCE.
REQ-013 IDLE: if wb_we_i is high, SHALL grant WB, with lu_ready_o=0.
  - IDLE, wb_we_i high and lu_valid_i high: SHALL go to WAIT with starve_cnt=1.
  - IDLE, wb_we_i low and lu_valid_i high: SHALL grant LU, with lu_ready_o=1.
REQ-014 WAIT: a WB request SHALL keep priority.
  - Each cycle LU is blocked, starve_cnt SHALL increment.
  - When starve_cnt reaches STARVE_LIMIT (3) while blocked, the next state SHALL be FORCE and stall_req_o SHALL be set to 1.
  - When LU is granted, SHALL return to IDLE with starve_cnt cleared.
REQ-015 FORCE: LU SHALL be granted regardless of wb_we_i, and the WB write SHALL be suppressed because the stalled pipeline re-presents it.
  - On the LU handshake, SHALL go to IDLE and clear stall_req_o at that clock edge.
REQ-016 If lu_valid_i drops in WAIT or FORCE, SHALL go to IDLE, clear starve_cnt and clear stall_req_o.
REQ-017 The write-port outputs SHALL be combinational from the inputs and the state, with zero added latency; the GPR commits at the next rising edge.
  - With no grant, rd_write_o=0, rd_addr_o=0 and write_data_o=0.
REQ-018 Scoreboard: a 32-bit busy vector.
  - issue_i sets busy[issue_addr_i].
  - An LU handshake clears busy[lu_addr_i].
  - A same-cycle set and clear of the same address SHALL leave the bit set.
  - busy[0] SHALL always read 0.
REQ-019 hazard_o SHALL be high when (rd1_addr_i≠0 and busy[rd1_addr_i]) or (rd2_addr_i≠0 and busy[rd2_addr_i]).
  - hazard_o SHALL use the registered busy vector only, with no same-cycle bypass of a clear.
REQ-020 An LU request with lu_addr_i=0 SHALL be granted and passed through unchanged; the GPR discards it.
REQ-021 A WB grant SHALL NOT modify the scoreboard.

Reset
REQ-022 While rst is high, the FSM SHALL be IDLE, starve_cnt=0, busy=0 and stall_req_o=0.
REQ-023 While rst is high, lu_ready_o=0, rd_write_o=0, rd_addr_o=0, write_data_o=0 and hazard_o=0.
REQ-024 A reset asserted mid-WAIT or mid-FORCE SHALL abandon the pending LU grant.
  - The requester SHALL keep lu_valid_i high, and the arbitration SHALL restart from IDLE after reset.

Structure
REQ-025 STARVE_LIMIT, the state encoding and the 5/32-bit register widths SHALL reside in the shared define file.
REQ-026 The scoreboard SHALL be the sub-module gpr_scoreboard.
  - Inputs: set, set_addr, clr, clr_addr, two query addresses.
  - Outputs: two busy bits.
REQ-027 The FSM, starve counter and write-port mux SHALL live in gpr_write_arbiter.

Verification
REQ-028 lu_valid_i=1 (addr 5, data 0xA5A5A5A5) with wb_we_i=0 -> same cycle: lu_ready_o=1, rd_write_o=1, rd_addr_o=5, write_data_o=0xA5A5A5A5; busy[5] cleared at the next edge.
REQ-029 wb_we_i and lu_valid_i held high continuously -> WB granted for 3 cycles; stall_req_o=1 from cycle 4; in FORCE, LU is granted with rd_write_o carrying LU data; stall_req_o=0 on the following cycle.
REQ-030 issue_i with issue_addr_i=7, then rd1_addr_i=7 -> hazard_o=1 from the next cycle until the edge after the LU handshake for addr 7; rd2_addr_i=0 never raises hazard_o.
REQ-031 Same-cycle issue_i to addr 9 and LU handshake to addr 9 -> busy[9] remains 1.
REQ-032 rst pulsed while in FORCE with lu_valid_i held -> stall_req_o=0 and lu_ready_o=0 during reset; after release, IDLE grants LU if wb_we_i=0.
